// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage holding the PC, issuing one memory request at a time
// and presenting the fetched word in an IF/ID register with redirect-based wrong-path kill.
module fetch_stage #(
   parameter int ADDR_W = 8,
   parameter int INSTR_W = 16,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [3:0]         if_opcode,
   output logic [ADDR_W-1:0]  if_pc,
   input  logic               id_ready,
   input  logic               redirect_valid,
   input  logic [ADDR_W-1:0]  redirect_pc
);
   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DRAIN} state_t;
   state_t state, state_n;
   logic [ADDR_W-1:0] pc, pc_n, req_addr, req_addr_n, if_pc_n;
   logic [INSTR_W-1:0] if_instr_n;
   logic if_valid_n;

   assign imem_req  = (state == FETCH) | (state == DRAIN);
   assign imem_addr = req_addr;
   assign if_opcode = if_instr[INSTR_W-1 -: 4];

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         pc       <= RESET_PC;
         req_addr <= RESET_PC;
         if_valid <= 1'b0;
         if_instr <= '0;
         if_pc    <= '0;
      end else begin
         state    <= state_n;
         pc       <= pc_n;
         req_addr <= req_addr_n;
         if_valid <= if_valid_n;
         if_instr <= if_instr_n;
         if_pc    <= if_pc_n;
      end

   always_comb begin
      state_n    = state;
      pc_n       = pc;
      req_addr_n = req_addr;
      if_valid_n = if_valid;
      if_instr_n = if_instr;
      if_pc_n    = if_pc;
      case (state)
         IDLE: begin
            state_n    = FETCH;
            req_addr_n = pc;
         end
         FETCH:
            if (imem_ack && redirect_valid) begin
               pc_n       = redirect_pc;
               req_addr_n = redirect_pc;
            end else if (imem_ack) begin
               if_instr_n = imem_rdata;
               if_pc_n    = req_addr;
               if_valid_n = 1'b1;
               pc_n       = pc + ADDR_W'(1);
               state_n    = HOLD;
            end else if (redirect_valid) begin
               pc_n    = redirect_pc;
               state_n = DRAIN;
            end
         HOLD:
            if (redirect_valid || id_ready) begin
               if_valid_n = 1'b0;
               pc_n       = redirect_valid ? redirect_pc : pc;
               req_addr_n = redirect_valid ? redirect_pc : pc;
               state_n    = FETCH;
            end
         DRAIN: begin
            // stale response is thrown away; a redirect arriving with it still wins
            pc_n = redirect_valid ? redirect_pc : pc;
            if (imem_ack) begin
               req_addr_n = redirect_valid ? redirect_pc : pc;
               state_n    = FETCH;
            end
         end
         default: state_n = IDLE;
      endcase
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed stimulus with a scoreboard of expected fetched PCs checked by a
// separate monitor on every IF/ID transfer.
module tb_fetch_stage;
   logic clk = 1'b0, rst = 1'b0;
   logic imem_req, imem_ack, if_valid, id_ready, redirect_valid;
   logic [7:0] imem_addr, if_pc, redirect_pc;
   logic [15:0] imem_rdata, if_instr;
   logic [3:0] if_opcode;
   logic [7:0] sb[$];
   int total = 0, bad = 0, lat = 1, mcnt = 0;
   logic mem_en = 1'b1;
   logic [15:0] held_instr;

   fetch_stage dut (
      .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
      .imem_rdata(imem_rdata), .if_valid(if_valid), .if_instr(if_instr), .if_opcode(if_opcode),
      .if_pc(if_pc), .id_ready(id_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] mem(input logic [7:0] a);
      return {a[3:0] ^ 4'h9, 4'h3, a};
   endfunction

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", n, a, e);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_empty();
      for (int i = 0; i < 300 && sb.size() != 0; i++) step();
      chk("sb_drain", sb.size(), 0);
   endtask

   task automatic wait_valid();
      for (int i = 0; i < 50 && !if_valid; i++) step();
      chk("wait_valid", if_valid, 1);
   endtask

   // instruction memory: ack arrives lat cycles after each request starts
   initial forever begin
      @(posedge clk);
      #1;
      if (!mem_en) mcnt = 0;
      else if (rst || !imem_req) begin
         imem_ack = 1'b0;
         mcnt = 0;
      end else begin
         if (imem_ack) mcnt = 0;
         mcnt++;
         imem_ack = (mcnt >= lat);
         imem_rdata = imem_ack ? mem(imem_addr) : 16'h0;
      end
   end

   initial forever begin
      @(negedge clk);
      if (!rst && if_valid && id_ready && !redirect_valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_xfer: got pc %0h expected none", if_pc);
         end else begin
            logic [7:0] e;
            e = sb.pop_front();
            chk("xfer_pc", if_pc, e);
            chk("xfer_instr", if_instr, mem(e));
            chk("xfer_opcode", if_opcode, e[3:0] ^ 4'h9);
         end
      end
   end

   initial begin
      imem_ack = 0; imem_rdata = 0; id_ready = 0; redirect_valid = 0; redirect_pc = 0;
      #1 rst = 1'b1;
      #1;
      chk("rst_req", imem_req, 0);
      chk("rst_valid", if_valid, 0);
      chk("rst_instr", if_instr, 0);
      chk("rst_pc", if_pc, 0);
      chk("rst_addr", imem_addr, 0);
      step();
      rst = 1'b0; lat = 1; id_ready = 1'b1;
      for (int i = 0; i < 6; i++) sb.push_back(8'(i));
      wait_empty();
      id_ready = 1'b0;
      // stall with a held word
      wait_valid();
      held_instr = if_instr;
      lat = 4;
      for (int i = 0; i < 5; i++) begin
         step();
         chk("stall_instr", if_instr, mem(8'h06));
         chk("stall_pc", if_pc, 8'h06);
         chk("stall_req", imem_req, 0);
         chk("stall_addr", imem_addr, 8'h06);
      end
      chk("stall_held", held_instr, mem(8'h06));
      sb.push_back(8'h06);
      id_ready = 1'b1;
      step();
      id_ready = 1'b0;
      // redirect while the request for 7 is outstanding
      step();
      redirect_valid = 1'b1; redirect_pc = 8'h40;
      step();
      redirect_valid = 1'b0;
      chk("drain_req", imem_req, 1);
      for (int i = 0; i < 20 && imem_addr == 8'h07; i++) step();
      chk("drain_next_addr", imem_addr, 8'h40);
      sb.push_back(8'h40);
      id_ready = 1'b1;
      wait_empty();
      id_ready = 1'b0;
      lat = 2;
      // redirect coinciding with the ack
      sb.push_back(8'h41);
      sb.push_back(8'h10);
      id_ready = 1'b1;
      for (int i = 0; i < 50 && !(imem_ack && imem_addr == 8'h42); i++) begin
         step();
         #1;
      end
      chk("ack_hunt", imem_addr, 8'h42);
      redirect_valid = 1'b1; redirect_pc = 8'h10;
      step();
      redirect_valid = 1'b0;
      chk("same_cyc_req", imem_req, 1);
      chk("same_cyc_addr", imem_addr, 8'h10);
      chk("same_cyc_valid", if_valid, 0);
      wait_empty();
      id_ready = 1'b0;
      // redirect beats id_ready in HOLD
      wait_valid();
      chk("hold_pc", if_pc, 8'h11);
      sb.push_back(8'h22);
      id_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 8'h22;
      step();
      redirect_valid = 1'b0;
      chk("kill_valid", if_valid, 0);
      chk("kill_req", imem_req, 1);
      chk("kill_addr", imem_addr, 8'h22);
      wait_empty();
      id_ready = 1'b0;
      // address wrap
      wait_valid();
      redirect_valid = 1'b1; redirect_pc = 8'hFF;
      step();
      redirect_valid = 1'b0;
      chk("wrap_addr", imem_addr, 8'hFF);
      sb.push_back(8'hFF);
      sb.push_back(8'h00);
      id_ready = 1'b1;
      wait_empty();
      id_ready = 1'b0;
      lat = 4;
      // reset during an outstanding request, then a late ack
      step();
      chk("pre_rst_req", imem_req, 1);
      mem_en = 1'b0;
      rst = 1'b1;
      #1;
      chk("mid_rst_req", imem_req, 0);
      chk("mid_rst_valid", if_valid, 0);
      chk("mid_rst_addr", imem_addr, 0);
      step();
      rst = 1'b0;
      imem_ack = 1'b1; imem_rdata = 16'hDEAD;
      step();
      imem_ack = 1'b0;
      mem_en = 1'b1;
      chk("late_ack_valid", if_valid, 0);
      chk("restart_req", imem_req, 1);
      chk("restart_addr", imem_addr, 8'h00);
      sb.push_back(8'h00);
      sb.push_back(8'h01);
      id_ready = 1'b1;
      wait_empty();
      id_ready = 1'b0;
      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
